dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: READ_LAT, default 2, read latency in cycles from request acceptance to rvalid; legal range 1..4.
REQ-002 Parameter: DEPTH, default 256, data storage size in 32-bit words, word-addressed by addr[9:2].
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-high (asserted = 1), sampled on the rising edge of clk.
REQ-005 req  input  1  access request from the datapath.
REQ-006 we  input  1  1 = store, 0 = load; qualified by req.
REQ-007 addr  input  32  byte address (the datapath ALU result).
REQ-008 func3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 wdata  input  32  store data (the datapath rs2 value), least-significant bytes used.
REQ-010 ready  output  1  responder can accept a request this cycle.
REQ-011 rvalid  output  1  one-cycle pulse; rdata holds load result.
REQ-012 rdata  output  32  load result, sign- or zero-extended per func3.
REQ-013 err  output  1  one-cycle pulse; the accepted request was rejected.

Function
REQ-014 A request SHALL be accepted on a rising edge where req=1 and ready=1; addr, we, func3 and wdata SHALL be captured at that edge.
REQ-015 The FSM SHALL have states IDLE, RD_WAIT and RESP; ready=1 only in IDLE.
REQ-016 IDLE -> RD_WAIT on acceptance of a legal load; RD_WAIT holds a down-counter loaded with READ_LAT-1; RD_WAIT -> RESP when counter = 0; RESP -> IDLE after one cycle.
REQ-017 With READ_LAT=1, RD_WAIT SHALL last zero cycles (IDLE -> RESP directly).
REQ-018 In RESP, rvalid=1 for exactly one cycle; rvalid SHALL rise READ_LAT cycles after the accepting edge; ready SHALL be 0 in RESP.
REQ-019 A legal store SHALL update storage at the accepting edge; the FSM stays in IDLE; ready stays 1; no rvalid pulse.
REQ-020 Stores: SB writes byte lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all four lanes; other lanes unchanged.
REQ-021 Loads: B/BU select byte lane addr[1:0], H/HU select halfword addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged; little-endian lane order.
REQ-022 A request is illegal if: H/HU with addr[0]=1; W with addr[1:0]!=00; load func3 in {011,110,111}; store func3 not in {000,001,010}; addr[31:10] != 0.
REQ-023 Illegal request: err=1 for the one cycle after the accepting edge; no storage change; no rvalid; FSM stays in IDLE; ready stays 1.
REQ-024 rdata SHALL hold its last value outside RESP; it is meaningful only when rvalid=1.
REQ-025 req while ready=0 SHALL be ignored (not queued); the datapath must hold or re-issue.
REQ-026 Back-to-back: a request asserted in the cycle after RESP SHALL be accepted (ready=1 in IDLE).
REQ-027 Storage contents SHALL NOT be initialised or cleared by reset.

Reset
REQ-028 While rst_n=1: state=IDLE, counter=0, ready=1 from the first cycle after the reset edge, rvalid=0, err=0, rdata=32'h0.
REQ-029 Reset during RD_WAIT or RESP SHALL abort the load with no rvalid pulse; a store accepted on the same edge as reset SHALL NOT modify storage.

Verification
REQ-030 SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 (READ_LAT=2) -> rvalid exactly 2 cycles after acceptance, rdata=0xDEADBEEF, ready low for 2 cycles.
REQ-031 After REQ-030: LB addr=0x13 -> rdata=0xFFFFFFDE; LBU addr=0x13 -> 0x000000DE; LH addr=0x12 -> 0xFFFFDEAD; LHU addr=0x10 -> 0x0000BEEF.
REQ-032 SB addr=0x11 wdata=0x00000055 then LW addr=0x10 -> rdata=0xDEAD55EF.
REQ-033 LW addr=0x12, SH addr=0x11, LB func3=011, SW addr=0x400 -> err pulse one cycle each, no rvalid, memory word 0x10 unchanged.
REQ-034 LW accepted, rst_n=1 for one cycle during RD_WAIT -> no rvalid, ready=1 the cycle after reset; subsequent LW addr=0x10 returns 0xDEAD55EF.
REQ-035 req held high continuously with LW to 0x10 and 0x14 -> second accepted on the cycle after RESP, and req during RD_WAIT/RESP not accepted.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: single-ported word store with byte/half/word access,
// load latency of READ_LAT cycles and a one-cycle error pulse for illegal requests.
module dmem_responder #(
   parameter int READ_LAT = 2,
   parameter int DEPTH    = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [2:0]  func3,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [31:0] ld_q;

   logic [31:0] mem [DEPTH];

   logic          accept;
   logic          is_half;
   logic          is_word;
   logic          misalign;
   logic          bad_f3;
   logic          oob;
   logic          illegal;
   logic [IW-1:0] idx;
   logic [31:0]   word;
   logic [31:0]   ld_val;
   logic [3:0]    be;
   logic [31:0]   wd_lane;

   function automatic logic [31:0] load_ext(input logic [31:0] w,
                                            input logic [1:0]  a,
                                            input logic [2:0]  f);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (f)
         3'b000:  load_ext = {{24{b[7]}}, b};
         3'b100:  load_ext = {24'h0, b};
         3'b001:  load_ext = {{16{h[15]}}, h};
         3'b101:  load_ext = {16'h0, h};
         default: load_ext = w;
      endcase
   endfunction

   always_comb begin
      accept   = req && ready;
      idx      = addr[IW+1:2];
      word     = mem[idx];
      is_half  = (func3[1:0] == 2'b01);
      is_word  = (func3[1:0] == 2'b10);
      misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
      // Stores only have B/H/W; loads additionally allow BU/HU.
      if (we)
         bad_f3 = func3[2] || (func3[1:0] == 2'b11);
      else
         bad_f3 = (func3 == 3'b011) || (func3[2:1] == 2'b11);
      oob      = (addr[31:2] >= 30'(DEPTH));
      illegal  = misalign || bad_f3 || oob;
      ld_val   = load_ext(word, addr[1:0], func3);
   end

   // Byte enables and lane-replicated store data.
   always_comb begin
      be      = 4'b0000;
      wd_lane = wdata;
      case (func3[1:0])
         2'b00: begin
            be      = 4'b0001 << addr[1:0];
            wd_lane = {4{wdata[7:0]}};
         end
         2'b01: begin
            be      = addr[1] ? 4'b1100 : 4'b0011;
            wd_lane = {2{wdata[15:0]}};
         end
         2'b10: begin
            be      = 4'b1111;
            wd_lane = wdata;
         end
         default: begin
            be      = 4'b0000;
            wd_lane = wdata;
         end
      endcase
   end

   // Storage is never reset; a store coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n && accept && we && !illegal) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i])
               mem[idx][8*i +: 8] <= wd_lane[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state  <= IDLE;
         cnt    <= 2'd0;
         ld_q   <= 32'h0;
         ready  <= 1'b1;
         rvalid <= 1'b0;
         err    <= 1'b0;
         rdata  <= 32'h0;
      end else begin
         rvalid <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     err <= 1'b1;
                  end else if (!we) begin
                     ready <= 1'b0;
                     if (READ_LAT == 1) begin
                        state  <= RESP;
                        rvalid <= 1'b1;
                        rdata  <= ld_val;
                     end else begin
                        state <= RD_WAIT;
                        cnt   <= 2'(READ_LAT - 1);
                        ld_q  <= ld_val;
                     end
                  end
               end
            end
            RD_WAIT: begin
               // cnt counts remaining wait cycles; leaving when it would reach zero
               if (cnt == 2'd1) begin
                  state  <= RESP;
                  cnt    <= 2'd0;
                  rvalid <= 1'b1;
                  rdata  <= ld_q;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               state <= IDLE;
               ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
